// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD message arbiter slice.
package lcd_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GNT0,
        ARB_GNT1
    } arb_state_t;

    typedef enum logic [1:0] {
        ISS_IDLE,
        ISS_SETUP,
        ISS_HOLD,
        ISS_GUARD
    } iss_state_t;

    localparam logic LCD_EX_ACTIVE = 1'b0;
    localparam logic LCD_EX_IDLE   = 1'b1;

    localparam int HOLD_CYCLES_DEF = 30;
    localparam int MAX_CHARS_DEF   = 16;

endpackage

// File: rtl/lcd_byte_fifo.sv
// Byte FIFO with registered full/empty flags.
module lcd_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_d;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (do_push && !do_pop)
            count_d = count + 1'b1;
        else if (!do_push && do_pop)
            count_d = count - 1'b1;
    end

    // Power-of-two depth lets the pointers wrap by overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_d;
            full  <= (count_d == (AW+1)'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/lcd_msg_arbiter.sv
// Round-robin message arbiter feeding the HD44780 controller write port.
// Define LCD_MSG_CLIP_EN to drop characters beyond MAX_CHARS per message.
module lcd_msg_arbiter
    import lcd_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int MAX_CHARS   = MAX_CHARS_DEF,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ack,
    output logic       req0_grant,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ack,
    output logic       req1_grant,
    output logic [7:0] lcd_data,
    output logic       lcd_ex,
    input  logic       lcd_ready,
    output logic       busy
);
    localparam int CW = $clog2(MAX_CHARS + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    arb_state_t    arb_q, arb_d;
    iss_state_t    iss_q, iss_d;
    logic          ptr_q, ptr_d;
    logic [CW-1:0] cc_q, cc_d;
    logic [HW-1:0] hc_q, hc_d;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic [7:0]    sel_data;
    logic          sel_last;
    logic          accept;

    assign req0_grant = (arb_q == ARB_GNT0);
    assign req1_grant = (arb_q == ARB_GNT1);
    assign req0_ack   = req0_grant & req0_valid & ~fifo_full;
    assign req1_ack   = req1_grant & req1_valid & ~fifo_full;
    assign accept     = req0_ack | req1_ack;
    assign sel_data   = req1_grant ? req1_data : req0_data;
    assign sel_last   = req1_grant ? req1_last : req0_last;

`ifdef LCD_MSG_CLIP_EN
    assign fifo_push = accept & (cc_q < CW'(MAX_CHARS));
`else
    assign fifo_push = accept;
`endif

    assign busy = req0_grant | req1_grant | ~fifo_empty
                | (iss_q != ISS_IDLE);

    // ptr_q records the last granted requester; reset favours 0.
    always_comb begin
        arb_d = arb_q;
        ptr_d = ptr_q;
        cc_d  = cc_q;
        unique case (arb_q)
            ARB_IDLE: begin
                if (req0_valid && req1_valid)
                    arb_d = ptr_q ? ARB_GNT0 : ARB_GNT1;
                else if (req0_valid)
                    arb_d = ARB_GNT0;
                else if (req1_valid)
                    arb_d = ARB_GNT1;
            end
            ARB_GNT0, ARB_GNT1: begin
                if (accept) begin
                    if (sel_last) begin
                        arb_d = ARB_IDLE;
                        ptr_d = req1_grant;
                        cc_d  = '0;
                    end else if (cc_q != CW'(MAX_CHARS)) begin
                        cc_d = cc_q + 1'b1;
                    end
                end
            end
            default: arb_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        iss_d    = iss_q;
        hc_d     = hc_q;
        fifo_pop = 1'b0;
        unique case (iss_q)
            ISS_IDLE: begin
                if (!fifo_empty && lcd_ready)
                    iss_d = ISS_SETUP;
            end
            ISS_SETUP: begin
                fifo_pop = 1'b1;
                hc_d     = '0;
                iss_d    = ISS_HOLD;
            end
            ISS_HOLD: begin
                if (hc_q == HW'(HOLD_CYCLES - 1)) begin
                    hc_d  = '0;
                    iss_d = ISS_GUARD;
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            ISS_GUARD: begin
                if (hc_q == HW'(HOLD_CYCLES - 1)) begin
                    hc_d  = '0;
                    iss_d = ISS_IDLE;
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arb_q    <= ARB_IDLE;
            ptr_q    <= 1'b1;
            cc_q     <= '0;
            iss_q    <= ISS_IDLE;
            hc_q     <= '0;
            lcd_data <= 8'h00;
            lcd_ex   <= LCD_EX_IDLE;
        end else begin
            arb_q <= arb_d;
            ptr_q <= ptr_d;
            cc_q  <= cc_d;
            iss_q <= iss_d;
            hc_q  <= hc_d;
            if (iss_q == ISS_SETUP)
                lcd_data <= fifo_rdata;
            // Registered strobe lags the state by one edge.
            lcd_ex <= (iss_q == ISS_SETUP || iss_q == ISS_HOLD)
                    ? LCD_EX_ACTIVE : LCD_EX_IDLE;
        end
    end

    lcd_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (sel_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Scoreboard bench for lcd_msg_arbiter with HOLD_CYCLES=4.
module tb_lcd_msg_arbiter;
    localparam int HOLD = 4;
    localparam int MAXC = 16;
`ifdef LCD_MSG_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_last = 1'b0;
    logic       req0_ack;
    logic       req0_grant;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_last = 1'b0;
    logic       req1_ack;
    logic       req1_grant;
    logic [7:0] lcd_data;
    logic       lcd_ex;
    logic       lcd_ready = 1'b1;
    logic       busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];
    int g1_cycles = 0;
    logic m_prev = 1'b1;
    int m_low = 0;
    int m_high = 0;
    bit m_seen = 1'b0;

    always #5 clk = ~clk;

    lcd_msg_arbiter #(
        .HOLD_CYCLES (HOLD),
        .MAX_CHARS   (MAXC),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ack   (req0_ack),
        .req0_grant (req0_grant),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ack   (req1_ack),
        .req1_grant (req1_grant),
        .lcd_data   (lcd_data),
        .lcd_ex     (lcd_ex),
        .lcd_ready  (lcd_ready),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int id, input logic v,
                         input logic [7:0] d, input logic l);
        if (id == 0) begin
            req0_valid = v; req0_data = d; req0_last = l;
        end else begin
            req1_valid = v; req1_data = d; req1_last = l;
        end
    endtask

    function automatic logic ack_of(input int id);
        return (id == 0) ? req0_ack : req1_ack;
    endfunction

    function automatic logic gnt_of(input int id);
        return (id == 0) ? req0_grant : req1_grant;
    endfunction

    task automatic send_msg(input int id, input logic [7:0] base,
                            input int first, input int n,
                            input int budget, output int sent);
        int idx;
        idx = first;
        sent = 0;
        for (int cyc = 0; cyc < budget && idx < n; cyc++) begin
            @(negedge clk);
            drive(id, 1'b1, 8'(base + idx), idx == n - 1);
            #1;
            if (ack_of(id)) begin
                if (!CLIP || idx < MAXC)
                    sb.push_back(8'(base + idx));
                sent++;
                idx++;
                if (idx == n) begin
                    @(posedge clk);
                    #1;
                    drive(id, 1'b0, 8'h00, 1'b0);
                    check("gnt_release", gnt_of(id), 1'b0);
                end
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(posedge clk);
            #1;
            if (!busy && sb.size() == 0 && lcd_ex)
                break;
        end
        check("drain_busy", busy, 1'b0);
        check("drain_sb", sb.size(), 0);
    endtask

    task automatic arb_pair(input int first);
        int order[2];
        int k;
        bit d0;
        bit d1;
        k = 0; d0 = 0; d1 = 0;
        @(negedge clk);
        drive(0, 1'b1, 8'h30, 1'b1);
        drive(1, 1'b1, 8'h31, 1'b1);
        for (int cyc = 0; cyc < 100 && k < 2; cyc++) begin
            #1;
            d0 = req0_ack;
            d1 = req1_ack;
            if (d0) begin order[k] = 0; k++; sb.push_back(8'h30); end
            if (d1) begin order[k] = 1; k++; sb.push_back(8'h31); end
            @(negedge clk);
            if (d0) drive(0, 1'b0, 8'h00, 1'b0);
            if (d1) drive(1, 1'b0, 8'h00, 1'b0);
        end
        check("arb_count", k, 2);
        check("arb_first", order[0], first);
        check("arb_second", order[1], 1 - first);
    endtask

    // Output monitor: strobe shape and scoreboard pop on each falling ex.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                m_prev = 1'b1; m_low = 0; m_high = 0; m_seen = 1'b0;
            end else begin
                if (req1_grant)
                    g1_cycles++;
                if (m_prev && !lcd_ex) begin
                    if (m_seen)
                        check("ex_high_min", m_high >= HOLD, 1'b1);
                    check("sb_has_entry", sb.size() > 0, 1'b1);
                    if (sb.size() > 0)
                        check("lcd_data", lcd_data, sb.pop_front());
                    m_low = 1;
                    m_seen = 1'b1;
                end else if (!lcd_ex) begin
                    m_low++;
                end else if (!m_prev) begin
                    check("ex_low_width", m_low, HOLD + 1);
                    m_high = 1;
                end else begin
                    m_high++;
                end
                m_prev = lcd_ex;
            end
        end
    end

    initial begin
        int sent;
        #12;
        check("rst_ex", lcd_ex, 1'b1);
        check("rst_data", lcd_data, 8'h00);
        check("rst_gnt0", req0_grant, 1'b0);
        check("rst_gnt1", req1_grant, 1'b0);
        check("rst_ack0", req0_ack, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // "HI" from requester 0
        send_msg(0, 8'h48, 0, 2, 200, sent);
        check("hi_sent", sent, 2);
        wait_idle(400);

        // Round robin from reset
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        arb_pair(0);
        arb_pair(0);
        wait_idle(400);

        // Backpressure with the controller not ready
        lcd_ready = 1'b0;
        send_msg(1, 8'h60, 0, 6, 10, sent);
        check("stall_acks", sent, 4);
        check("stall_gnt", req1_grant, 1'b1);
        check("stall_ack0", req1_ack, 1'b0);
        lcd_ready = 1'b1;
        send_msg(1, 8'h60, 4, 6, 2000, sent);
        check("stall_rest", sent, 2);
        wait_idle(800);

        // Long message
        send_msg(0, 8'h41, 0, 20, 2000, sent);
        check("long_acks", sent, 20);
        wait_idle(800);

        // Reset while the strobe is held low
        send_msg(0, 8'h55, 0, 1, 100, sent);
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(posedge clk);
            #1;
            if (!lcd_ex) break;
        end
        check("pre_rst_ex", lcd_ex, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_ex", lcd_ex, 1'b1);
        check("mid_rst_data", lcd_data, 8'h00);
        check("mid_rst_gnt0", req0_grant, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        send_msg(0, 8'h5A, 0, 1, 100, sent);
        check("post_rst_sent", sent, 1);
        wait_idle(400);

        // Single-byte message on requester 1
        g1_cycles = 0;
        send_msg(1, 8'h2A, 0, 1, 100, sent);
        check("single_acks", sent, 1);
        wait_idle(400);
        check("single_gnt_cycles", g1_cycles, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_msg_arbiter.md
# lcd_msg_arbiter

Arbitrates two character-stream requesters onto the single data-write port of the HD44780 LCD controller. Each requester sends a message as a sequence of bytes terminated by a `last` flag. The block grants whole messages in round-robin order and buffers accepted bytes in a small FIFO. An issue FSM then drives the controller's active-low `ex` strobe with fixed hold and guard times. It sits between the display-producing logic (tape view, status line) and `lcd_controller`.

## Interface
Parameters:
- `HOLD_CYCLES`, 30: cycles `lcd_ex` is held low, and also the guard cycles it is held high after each byte.
- `MAX_CHARS`, 16: characters per message (one LCD line).
- `FIFO_DEPTH`, 4: byte FIFO entries; must be a power of two.

Ports (clock and reset first):
- `clk` input 1: single system clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req0_valid` input 1: requester 0 has a byte on `req0_data`.
- `req0_data` input 8: requester 0 character.
- `req0_last` input 1: current byte is the final byte of the message.
- `req0_ack` output 1: byte accepted this cycle (combinational).
- `req0_grant` output 1: requester 0 owns the stream.
- `req1_valid`, `req1_data`, `req1_last`, `req1_ack`, `req1_grant`: same as the requester 0 signals, for requester 1.
- `lcd_data` output 8: character to the controller `data` input.
- `lcd_ex` output 1: active-low execute strobe to the controller `ex` input.
- `lcd_ready` input 1: controller `ready`; high once the controller has finished initialisation.
- `busy` output 1: high when a grant is held, the FIFO is non-empty, or the issue FSM is not in `ISS_IDLE`.

## Operation
Arbiter FSM, states `ARB_IDLE`, `ARB_GNT0`, `ARB_GNT1`:
- `ARB_IDLE`:
  - One valid requester: grant it on the next edge.
  - Both valid: grant the one *not* granted last. The pointer resets to favour requester 0.
- `ARB_GNTn`:
  - `reqn_ack = reqn_valid & ~fifo_full`.
  - On an acked byte, the char counter increments (saturating at `MAX_CHARS`) and the byte is written to the FIFO (subject to clipping, see Configuration).
  - An acked byte with `last=1` returns the FSM to `ARB_IDLE` on the next edge, updates the pointer, and clears the char counter.
- The non-granted requester's ack is always 0. Its `valid` may stay high indefinitely.

Issue FSM, states `ISS_IDLE`, `ISS_SETUP`, `ISS_HOLD`, `ISS_GUARD`:
- `ISS_IDLE`: `lcd_ex=1`. Moves to `ISS_SETUP` when the FIFO is non-empty and `lcd_ready=1`.
- `ISS_SETUP`: pop the FIFO into `lcd_data` and drive `lcd_ex=0`. Then `ISS_HOLD`.
- `ISS_HOLD`: keep `lcd_ex=0` for `HOLD_CYCLES` cycles. Then `ISS_GUARD`.
- `ISS_GUARD`: `lcd_ex=1` for `HOLD_CYCLES` cycles. Then `ISS_IDLE`.
- `lcd_data` is stable from `ISS_SETUP` through the end of `ISS_GUARD`.
- Hold and guard counters are `$clog2(HOLD_CYCLES+1)` bits wide and load from 0.

Boundary conditions:
- FIFO full: ack is 0 and the requester stalls; no byte is lost.
- Simultaneous push and pop on a full FIFO: the pop frees the entry, but ack still uses the registered full flag, so that push is stalled one cycle.
- `lcd_ready=0`: the issue FSM waits in `ISS_IDLE`. Bytes accumulate until the FIFO is full.
- Single-byte message (`last` on the first byte): grant lasts exactly one accept.
- FIFO pointers wrap modulo `FIFO_DEPTH`.
- Reset asserted mid-operation takes effect immediately (asynchronous):
  - `lcd_ex=1`, `lcd_data=0`.
  - Grants and acks are 0, FSMs are in their idle states.
  - FIFO is flushed; the pointer favours requester 0.
  - A partially issued byte is abandoned.

## Timing
- Reset values: `lcd_ex=1`, `lcd_data=8'h00`, `req0_grant=req1_grant=0`, `req*_ack=0`, `busy=0`.
- The grant rises one cycle after `valid` is seen in `ARB_IDLE`. The first ack can occur in that same grant cycle.
- For a byte accepted at edge E into an empty FIFO with the issue FSM idle:
  - `lcd_ex` falls at edge E+2.
  - It stays low for `HOLD_CYCLES+1` cycles (`ISS_SETUP` plus `ISS_HOLD`).
  - It then stays high for `HOLD_CYCLES` cycles.
- Sustained throughput is one byte per `2*HOLD_CYCLES+2` cycles.
- Grant of the next message can overlap FIFO drain of the previous one.

## Configuration
- `LCD_MSG_CLIP_EN` defined:
  - Bytes accepted after `MAX_CHARS` characters in a message are still acked but are not written to the FIFO.
  - The `last` byte is discarded too if it is past the limit; the grant still releases on `last`.
- Not defined: every acked byte is written. The char counter only saturates and has no effect on data.

## Structure
- Shared package `lcd_pkg`:
  - Arbiter and issue state enums.
  - `LCD_EX_ACTIVE=1'b0` and `LCD_EX_IDLE=1'b1`.
  - Default values of `HOLD_CYCLES` and `MAX_CHARS`.
- Sub-module `lcd_byte_fifo`: synchronous FIFO, depth `FIFO_DEPTH`, 8 bits wide, with registered `full`/`empty` flags and asynchronous active-low reset on `rst`.

## Test plan
- Requester 0 sends "HI" (8'h48, then 8'h49 with `last`), `lcd_ready=1`, `HOLD_CYCLES=4` → `lcd_ex` has two low pulses of 5 cycles, each followed by 4 high cycles; `lcd_data` is 8'h48 then 8'h49; `req0_grant` drops after the second ack.
- Both requesters valid from reset → requester 0 is granted first; after its `last`, requester 1 is granted; a further simultaneous request grants requester 0.
- `lcd_ready=0` while requester 1 streams 6 bytes → 4 acks, then ack stays 0; raising `lcd_ready` drains all 6 bytes in order.
- With `LCD_MSG_CLIP_EN` and `MAX_CHARS=16`, send 20 bytes 8'h41..8'h54 → 20 acks, only 8'h41..8'h50 issued. Without the macro, all 20 are issued.
- Assert `rst` low during `ISS_HOLD` → `lcd_ex=1`, FIFO empty, grants 0 in the same cycle; after release, a new message is issued normally.
- Single-byte message 8'h2A with `last` on requester 1 → one ack, `req1_grant` high for exactly one cycle, one `lcd_ex` pulse carrying 8'h2A.
